// File: rtl/cla_topic_pkg.sv
// Shared definitions for the topic buffer arbiter: FSM state encodings,
// default client count and the default pointer width / reset port name.
// Optional feature macro: CLA_TOPIC_BUF_QUOTA_EN (per-client quota limiting).

`ifndef TOPIC_VALUE_DEPTH_NBITS
`define TOPIC_VALUE_DEPTH_NBITS 8
`endif

`ifndef RESET_SIG
`define RESET_SIG rst
`endif

package cla_topic_pkg;

    // Free-list sequencer states
    localparam logic [1:0] ST_WAIT_DONE = 2'd0;
    localparam logic [1:0] ST_RUN       = 2'd1;
    localparam logic [1:0] ST_REINIT    = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

    localparam int NUM_REQ_DEF = 4;

endpackage

// File: rtl/cla_rr_arb.sv
// Round-robin arbiter: one-hot grant from req, searching upward from a
// rotating priority pointer. The pointer moves to winner+1 only when the
// caller says the grant was actually used (advance).

module cla_rr_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] prio;
    logic [PW-1:0] win_idx;
    logic          found;

    // Pick the first requester at or after the priority pointer (wrapping)
    always_comb begin
        gnt     = '0;
        win_idx = prio;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(prio) + i) % N]) begin
                found                      = 1'b1;
                gnt[(int'(prio) + i) % N]  = 1'b1;
                win_idx                    = PW'((int'(prio) + i) % N);
            end
        end
    end

    // Rotate priority past the winner when the grant is consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prio <= '0;
        else if (advance && found)
            prio <= (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
    end

endmodule

// File: rtl/cla_topic_buf_arb.sv
// Topic value buffer free-list arbiter/sequencer. Shares the free list's
// single pop and release ports among NUM_REQ clients with round-robin
// fairness, and gates allocation while the free list is rebuilt.
// Optional feature macro: CLA_TOPIC_BUF_QUOTA_EN adds per-client in-use
// counters, a quota input and a sticky release-underflow flag.

module cla_topic_buf_arb
    import cla_topic_pkg::*;
#(
    parameter int BPTR_NBITS  = `TOPIC_VALUE_DEPTH_NBITS,
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int QUOTA_NBITS = BPTR_NBITS + 1
) (
    input  logic                          clk,
    input  logic                          `RESET_SIG,
    input  logic                          reinit_req,
    output logic                          reinit_busy,
    input  logic [NUM_REQ-1:0]            alloc_req,
    output logic [NUM_REQ-1:0]            alloc_gnt,
    output logic [BPTR_NBITS-1:0]         alloc_ptr,
    input  logic [NUM_REQ-1:0]            rel_req,
    input  logic [NUM_REQ*BPTR_NBITS-1:0] rel_ptr,
    output logic [NUM_REQ-1:0]            rel_ack,
    output logic                          fl_init,
    input  logic                          fl_init_done,
    input  logic                          fl_empty,
    input  logic [BPTR_NBITS-1:0]         fl_ptr,
    output logic                          fl_rd,
    output logic                          fl_rel_valid,
    output logic [BPTR_NBITS-1:0]         fl_rel_ptr
`ifdef CLA_TOPIC_BUF_QUOTA_EN
    ,
    input  logic [NUM_REQ*QUOTA_NBITS-1:0] quota,
    output logic                           quota_err
`endif
);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  run;
    logic                  enter_reinit;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    alloc_win;
    logic [NUM_REQ-1:0]    rel_win;
    logic [BPTR_NBITS-1:0] rel_sel;

    assign run          = (state == ST_RUN);
    assign enter_reinit = run && reinit_req;
    assign reinit_busy  = !run;

    // Rebuild sequencer: RUN -> REINIT (1 cycle) -> wait done low -> wait done high
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_DONE: if (fl_init_done)  state_nxt = ST_RUN;
            ST_RUN:       if (reinit_req)    state_nxt = ST_REINIT;
            ST_REINIT:                       state_nxt = ST_WAIT_LOW;
            ST_WAIT_LOW:  if (!fl_init_done) state_nxt = ST_WAIT_DONE;
            default:                         state_nxt = ST_WAIT_DONE;
        endcase
    end

    // State register; reset lands in WAIT_DONE since the list self-initialises
    always_ff @(posedge clk or posedge `RESET_SIG) begin
        if (`RESET_SIG)
            state <= ST_WAIT_DONE;
        else
            state <= state_nxt;
    end

`ifdef CLA_TOPIC_BUF_QUOTA_EN
    logic [NUM_REQ-1:0][QUOTA_NBITS-1:0] cnt;
    logic [NUM_REQ-1:0]                  underflow;

    // A client is eligible only while its in-use count is below its quota
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = alloc_req[i] &&
                          (cnt[i] < quota[i*QUOTA_NBITS +: QUOTA_NBITS]);
    end

    // Underflow: a counted release hitting a client that holds nothing
    always_comb begin
        underflow = '0;
        for (int i = 0; i < NUM_REQ; i++)
            underflow[i] = run && rel_win[i] && !(fl_rd && alloc_win[i]) &&
                           (cnt[i] == '0);
    end

    // In-use counters: +1 on grant, -1 on release, cleared when rebuilding
    always_ff @(posedge clk or posedge `RESET_SIG) begin
        if (`RESET_SIG) begin
            cnt <= '0;
        end else if (enter_reinit) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((fl_rd && alloc_win[i]) && !(run && rel_win[i]))
                    cnt[i] <= cnt[i] + 1'b1;
                else if (!(fl_rd && alloc_win[i]) && run && rel_win[i] &&
                         (cnt[i] != '0))
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    // Sticky underflow flag, only reset clears it
    always_ff @(posedge clk or posedge `RESET_SIG) begin
        if (`RESET_SIG)
            quota_err <= 1'b0;
        else if (|underflow)
            quota_err <= 1'b1;
    end
`else
    assign eligible = alloc_req;
`endif

    // Pop only in RUN with something to hand out; the pop and arbitration share a cycle
    assign fl_rd = run && !fl_empty && (|eligible);

    cla_rr_arb #(.N(NUM_REQ)) u_alloc_arb (
        .clk     (clk),
        .rst     (`RESET_SIG),
        .req     (eligible),
        .advance (fl_rd),
        .gnt     (alloc_win)
    );

    cla_rr_arb #(.N(NUM_REQ)) u_rel_arb (
        .clk     (clk),
        .rst     (`RESET_SIG),
        .req     (rel_req),
        .advance (|rel_req),
        .gnt     (rel_win)
    );

    // Releases are always accepted; outside RUN they are dropped
    assign rel_ack = rel_win;

    // One-hot mux of the winning client's release pointer
    always_comb begin
        rel_sel = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (rel_win[i])
                rel_sel = rel_sel | rel_ptr[i*BPTR_NBITS +: BPTR_NBITS];
    end

    // Registered grant pulse carrying the popped pointer
    always_ff @(posedge clk or posedge `RESET_SIG) begin
        if (`RESET_SIG) begin
            alloc_gnt <= '0;
            alloc_ptr <= '0;
        end else begin
            alloc_gnt <= fl_rd ? alloc_win : '0;
            if (fl_rd)
                alloc_ptr <= fl_ptr;
        end
    end

    // Registered release toward the free list, only while it is live
    always_ff @(posedge clk or posedge `RESET_SIG) begin
        if (`RESET_SIG) begin
            fl_rel_valid <= 1'b0;
            fl_rel_ptr   <= '0;
        end else begin
            fl_rel_valid <= run && (|rel_req);
            if (run && (|rel_req))
                fl_rel_ptr <= rel_sel;
        end
    end

    // Init pulse coincides with the single REINIT cycle
    always_ff @(posedge clk or posedge `RESET_SIG) begin
        if (`RESET_SIG)
            fl_init <= 1'b0;
        else
            fl_init <= enter_reinit;
    end

endmodule

// File: tb/tb_cla_topic_buf_arb.sv
// Scoreboard bench for cla_topic_buf_arb: the stimulus pushes expected
// grants/releases into queues, a negedge monitor pops and compares them
// whenever the DUT presents alloc_gnt or fl_rel_valid.

`ifndef RESET_SIG
`define RESET_SIG rst
`endif

module tb_cla_topic_buf_arb;

    localparam int N  = 4;
    localparam int BW = 8;
    localparam int QW = BW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reinit_req = 1'b0;
    logic          reinit_busy;
    logic [N-1:0]  alloc_req = '0;
    logic [N-1:0]  alloc_gnt;
    logic [BW-1:0] alloc_ptr;
    logic [N-1:0]  rel_req = '0;
    logic [N*BW-1:0] rel_ptr = '0;
    logic [N-1:0]  rel_ack;
    logic          fl_init;
    logic          fl_init_done = 1'b0;
    logic          fl_empty = 1'b1;
    logic [BW-1:0] fl_ptr = 8'h20;
    logic          fl_rd;
    logic          fl_rel_valid;
    logic [BW-1:0] fl_rel_ptr;
`ifdef CLA_TOPIC_BUF_QUOTA_EN
    logic [N*QW-1:0] quota = {9'h1FF, 9'h1FF, 9'h1FF, 9'd2};
    logic            quota_err;
`endif

    int errors = 0;
    int checks = 0;

    logic [11:0] aq[$];
    logic [7:0]  rq[$];
    logic [11:0] a_exp;
    logic [7:0]  r_exp;
    logic [3:0]  oh;

    always #5 clk = ~clk;

    cla_topic_buf_arb #(.BPTR_NBITS(BW), .NUM_REQ(N), .QUOTA_NBITS(QW)) dut (
        .clk          (clk),
        .`RESET_SIG   (rst),
        .reinit_req   (reinit_req),
        .reinit_busy  (reinit_busy),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_ptr    (alloc_ptr),
        .rel_req      (rel_req),
        .rel_ptr      (rel_ptr),
        .rel_ack      (rel_ack),
        .fl_init      (fl_init),
        .fl_init_done (fl_init_done),
        .fl_empty     (fl_empty),
        .fl_ptr       (fl_ptr),
        .fl_rd        (fl_rd),
        .fl_rel_valid (fl_rel_valid),
        .fl_rel_ptr   (fl_rel_ptr)
`ifdef CLA_TOPIC_BUF_QUOTA_EN
        ,
        .quota        (quota),
        .quota_err    (quota_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented grant/release must match the next expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (alloc_gnt != '0) begin
                if (aq.size() == 0) begin
                    check("unexpected_grant", {20'd0, alloc_gnt, alloc_ptr}, 32'd0);
                end else begin
                    a_exp = aq.pop_front();
                    check("alloc_grant", {20'd0, alloc_gnt, alloc_ptr}, {20'd0, a_exp});
                end
            end
            if (fl_rel_valid) begin
                if (rq.size() == 0) begin
                    check("unexpected_release", {23'd0, fl_rel_valid, fl_rel_ptr}, 32'd0);
                end else begin
                    r_exp = rq.pop_front();
                    check("release_ptr", {24'd0, fl_rel_ptr}, {24'd0, r_exp});
                end
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", reinit_busy, 1);
        check("rst_gnt", alloc_gnt, 0);
        check("rst_ptr", alloc_ptr, 0);
        check("rst_init", fl_init, 0);
        check("rst_relv", fl_rel_valid, 0);
        check("rst_relptr", fl_rel_ptr, 0);
`ifdef CLA_TOPIC_BUF_QUOTA_EN
        check("rst_qerr", quota_err, 0);
`endif
        step();
        rst = 1'b0;
        alloc_req = 4'b0001;
        fl_empty = 1'b0;

        // Free list not ready yet: no pops for 20 cycles
        repeat (20) begin
            @(negedge clk);
            check("no_rd_before_done", fl_rd, 0);
        end
        step();
        alloc_req = '0;
        fl_init_done = 1'b1;
        @(negedge clk);
        check("busy_same_cycle", reinit_busy, 1);
        step();
        @(negedge clk);
        check("busy_falls", reinit_busy, 0);
        step();

        // All clients requesting: grants rotate 0,1,2,3,0 back to back
        for (int k = 0; k < 5; k++) begin
            alloc_req = 4'b1111;
            fl_ptr = 8'h40 + 8'(k);
            oh = 4'b0001 << (k % 4);
            aq.push_back({oh, 8'h40 + 8'(k)});
            @(negedge clk);
            check("rr_rd", fl_rd, 1);
            step();
        end
        alloc_req = '0;

        // Concurrent alloc (client 1) and release (client 2, ptr 0x15)
        alloc_req = 4'b0010;
        rel_req = 4'b0100;
        rel_ptr = 32'h0015_0000;
        fl_ptr = 8'h50;
        aq.push_back({4'b0010, 8'h50});
        rq.push_back(8'h15);
        @(negedge clk);
        check("dual_rd", fl_rd, 1);
        check("dual_ack", rel_ack, 4'b0100);
        step();
        alloc_req = '0;
        rel_req = '0;

        // Empty free list stalls pending requests
        fl_empty = 1'b1;
        alloc_req = 4'b0101;
        repeat (3) begin
            @(negedge clk);
            check("empty_no_rd", fl_rd, 0);
            step();
        end
        fl_empty = 1'b0;
        fl_ptr = 8'h60;
        aq.push_back({4'b0100, 8'h60});
        @(negedge clk);
        check("unempty_rd", fl_rd, 1);
        step();
        alloc_req = '0;

        // Rebuild: init pulse, release acked but dropped, no pops
        reinit_req = 1'b1;
        step();
        reinit_req = 1'b0;
        rel_req = 4'b0001;
        rel_ptr = 32'h0000_0033;
        alloc_req = 4'b0001;
        @(negedge clk);
        check("reinit_init", fl_init, 1);
        check("reinit_busy", reinit_busy, 1);
        check("reinit_rel_ack", rel_ack, 4'b0001);
        check("reinit_no_rd", fl_rd, 0);
        step();
        rel_req = '0;
        @(negedge clk);
        check("init_one_cycle", fl_init, 0);
        check("waitlow_no_rd", fl_rd, 0);
        step();
        alloc_req = '0;
        fl_init_done = 1'b0;
        repeat (5) step();
        fl_init_done = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (!reinit_busy) break;
        end
        check("reinit_resume", reinit_busy, 0);
        step();

        // Traffic resumes after rebuild
        alloc_req = 4'b0010;
        fl_ptr = 8'h66;
        aq.push_back({4'b0010, 8'h66});
        @(negedge clk);
        check("resume_rd", fl_rd, 1);
        step();
        alloc_req = '0;

`ifdef CLA_TOPIC_BUF_QUOTA_EN
        // Client 0 quota 2: two grants then stall
        for (int k = 0; k < 4; k++) begin
            alloc_req = 4'b0001;
            fl_ptr = 8'h70 + 8'(k);
            if (k < 2) aq.push_back({4'b0001, 8'h70 + 8'(k)});
            @(negedge clk);
            check("quota_rd", fl_rd, (k < 2) ? 1 : 0);
            step();
        end
        alloc_req = '0;
        // One release re-enables one more grant
        rel_req = 4'b0001;
        rel_ptr = 32'h0000_0071;
        rq.push_back(8'h71);
        @(negedge clk);
        check("quota_rel_ack", rel_ack, 4'b0001);
        step();
        rel_req = '0;
        alloc_req = 4'b0001;
        fl_ptr = 8'h80;
        aq.push_back({4'b0001, 8'h80});
        @(negedge clk);
        check("quota_reenable", fl_rd, 1);
        check("quota_err_clear", quota_err, 0);
        step();
        alloc_req = '0;
        // Release from client 2 which holds nothing
        rel_req = 4'b0100;
        rel_ptr = 32'h0012_0000;
        rq.push_back(8'h12);
        @(negedge clk);
        check("underflow_ack", rel_ack, 4'b0100);
        step();
        rel_req = '0;
        @(negedge clk);
        check("quota_err_set", quota_err, 1);
        step();
`endif

        repeat (3) @(negedge clk);
        check("alloc_queue_drained", aq.size(), 0);
        check("rel_queue_drained", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
